// File: rtl/ts_pkg.sv
// Shared MPEG2-TS constants, encodings and header payload type.
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int unsigned TS_PKT_LEN   = 188;
  localparam int unsigned TS_IDX_W     = 8;
  localparam int unsigned TS_PID_W     = 13;
  localparam int unsigned TS_CC_W      = 4;
  localparam int unsigned ERR_CNT_W    = 8;
  localparam int unsigned IDLE_W       = 20;
  localparam logic [TS_PID_W-1:0] TS_NULL_PID = 13'h1FFF;

  typedef enum logic [1:0] {
    AFC_RSVD    = 2'b00,
    AFC_PAYLOAD = 2'b01,
    AFC_ADAPT   = 2'b10,
    AFC_BOTH    = 2'b11
  } afc_e;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  // Header fields captured from bytes 1 and 2 of a packet
  typedef struct packed {
    logic                tei;
    logic [TS_PID_W-1:0] pid;
  } ts_hdr_t;

  // Next byte position within a packet, wrapping at the packet length
  function automatic logic [TS_IDX_W-1:0] idx_inc(input logic [TS_IDX_W-1:0] idx);
    return (idx == TS_IDX_W'(TS_PKT_LEN - 1)) ? '0 : TS_IDX_W'(idx + TS_IDX_W'(1));
  endfunction

endpackage

// File: rtl/ts_cc_monitor_if.sv
// TS byte stream: one byte per ts_valid cycle, no backpressure.
interface ts_cc_monitor_if;
  import ts_pkg::*;

  logic [7:0] ts_data;
  logic       ts_valid;

  modport master (output ts_data, output ts_valid);
  modport slave  (input  ts_data, input  ts_valid);
endinterface

// File: rtl/ts_sync_lock.sv
// Packet sync acquisition: tracks byte position and HUNT/VERIFY/LOCKED state.
module ts_sync_lock
  import ts_pkg::*;
#(
  parameter int unsigned       LOCK_CNT     = 3,
  parameter int unsigned       LOSS_CNT     = 3,
  parameter logic [IDLE_W-1:0] IDLE_TIMEOUT = 20'd1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          ts_data,
  input  logic                ts_valid,
  output logic                locked,
  output logic                parse_en,
  output logic [TS_IDX_W-1:0] byte_idx
);

  localparam int unsigned CNT_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  sync_state_e         state, state_nxt;
  logic [TS_IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0]    good, good_nxt, miss, miss_nxt;
  logic [IDLE_W-1:0]   idle, idle_nxt;
  logic                is_sync;

  assign is_sync = (ts_data == TS_SYNC_BYTE);

  // State register plus counters; locked/parse_en registered from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      byte_idx <= '0;
      good     <= '0;
      miss     <= '0;
      idle     <= '0;
      locked   <= 1'b0;
      parse_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
      good     <= good_nxt;
      miss     <= miss_nxt;
      idle     <= idle_nxt;
      locked   <= (state_nxt == LOCKED);
      parse_en <= (state_nxt == LOCKED) && (miss_nxt == '0);
    end
  end

  // Next-state: sync byte checks at index 0, idle timeout when no byte arrives
  always_comb begin
    state_nxt = state;
    idx_nxt   = byte_idx;
    good_nxt  = good;
    miss_nxt  = miss;
    idle_nxt  = ts_valid ? '0 : ((idle == '1) ? idle : IDLE_W'(idle + IDLE_W'(1)));
    if (ts_valid) begin
      idx_nxt = idx_inc(byte_idx);
      case (state)
        HUNT: begin
          if (is_sync) begin
            state_nxt = VERIFY;
            good_nxt  = CNT_W'(1);
            idx_nxt   = TS_IDX_W'(1);
          end else begin
            idx_nxt = '0;
          end
        end
        VERIFY: begin
          if (byte_idx == '0) begin
            if (is_sync) begin
              good_nxt = CNT_W'(good + CNT_W'(1));
              if (good_nxt == CNT_W'(LOCK_CNT)) begin
                state_nxt = LOCKED;
                miss_nxt  = '0;
              end
            end else begin
              state_nxt = HUNT;
              idx_nxt   = '0;
            end
          end
        end
        LOCKED: begin
          if (byte_idx == '0) begin
            if (is_sync) begin
              miss_nxt = '0;
            end else begin
              miss_nxt = CNT_W'(miss + CNT_W'(1));
              if (miss_nxt == CNT_W'(LOSS_CNT)) begin
                state_nxt = HUNT;
                idx_nxt   = '0;
              end
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          idx_nxt   = '0;
        end
      endcase
    end else if (idle >= IDLE_TIMEOUT) begin
      state_nxt = HUNT;
      idx_nxt   = '0;
    end
  end

endmodule

// File: rtl/ts_cc_monitor.sv
// Per-channel TS monitor: sync lock, header parse, CC/TEI check, error count.
module ts_cc_monitor
  import ts_pkg::*;
#(
  parameter int unsigned       LOCK_CNT     = 3,
  parameter int unsigned       LOSS_CNT     = 3,
  parameter logic [IDLE_W-1:0] IDLE_TIMEOUT = 20'd1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  ts_cc_monitor_if.slave       ts_bus,
  input  logic [TS_PID_W-1:0]  pid_sel,
  input  logic                 reset_counter,
  output logic                 signal_present,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 cc_err,
  output logic                 pkt_strobe
);

  logic                 locked, parse_en;
  logic [TS_IDX_W-1:0]  byte_idx;
  ts_hdr_t              hdr_q, hdr_nxt;
  logic [TS_CC_W-1:0]   ref_cc, ref_nxt, cc_c;
  logic                 ref_valid, ref_valid_nxt, dup, dup_nxt;
  logic [TS_PID_W-1:0]  pid_sel_q;
  logic                 err_c, strobe_c;
  logic [ERR_CNT_W-1:0] cnt_nxt;
  afc_e                 afc_c;

  ts_sync_lock #(
    .LOCK_CNT    (LOCK_CNT),
    .LOSS_CNT    (LOSS_CNT),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .ts_data (ts_bus.ts_data),
    .ts_valid(ts_bus.ts_valid),
    .locked  (locked),
    .parse_en(parse_en),
    .byte_idx(byte_idx)
  );

  assign signal_present = locked;
  assign afc_c          = afc_e'(ts_bus.ts_data[5:4]);
  assign cc_c           = ts_bus.ts_data[3:0];

  // Checker state and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q      <= '0;
      ref_cc     <= '0;
      ref_valid  <= 1'b0;
      dup        <= 1'b0;
      pid_sel_q  <= '0;
      cc_err     <= 1'b0;
      pkt_strobe <= 1'b0;
      err_count  <= '0;
    end else begin
      hdr_q      <= hdr_nxt;
      ref_cc     <= ref_nxt;
      ref_valid  <= ref_valid_nxt;
      dup        <= dup_nxt;
      pid_sel_q  <= pid_sel;
      cc_err     <= err_c;
      pkt_strobe <= strobe_c;
      err_count  <= cnt_nxt;
    end
  end

  // Header capture on bytes 1-2, continuity/TEI check on byte 3
  always_comb begin
    hdr_nxt       = hdr_q;
    ref_nxt       = ref_cc;
    ref_valid_nxt = ref_valid;
    dup_nxt       = dup;
    err_c         = 1'b0;
    strobe_c      = 1'b0;
    if (ts_bus.ts_valid && parse_en) begin
      case (byte_idx)
        TS_IDX_W'(1): begin
          hdr_nxt.tei       = ts_bus.ts_data[7];
          hdr_nxt.pid[12:8] = ts_bus.ts_data[4:0];
        end
        TS_IDX_W'(2): hdr_nxt.pid[7:0] = ts_bus.ts_data;
        TS_IDX_W'(3): begin
          strobe_c = 1'b1;
          if ((hdr_q.pid == pid_sel) && (pid_sel != TS_NULL_PID)) begin
            if (hdr_q.tei) begin
              err_c = 1'b1;
            end else if (afc_c == AFC_RSVD) begin
              err_c = 1'b0;
            end else if (!ref_valid) begin
              ref_nxt       = cc_c;
              ref_valid_nxt = 1'b1;
              dup_nxt       = 1'b0;
            end else if ((afc_c == AFC_PAYLOAD) || (afc_c == AFC_BOTH)) begin
              ref_nxt = cc_c;
              if (cc_c == TS_CC_W'(ref_cc + TS_CC_W'(1))) begin
                dup_nxt = 1'b0;
              end else if (cc_c == ref_cc) begin
                // First repeat is a legal duplicate; a further repeat is not
                err_c   = dup;
                dup_nxt = 1'b1;
              end else begin
                err_c   = 1'b1;
                dup_nxt = 1'b0;
              end
            end else begin
              ref_nxt = cc_c;
              err_c   = (cc_c != ref_cc);
            end
          end
        end
        default: ;
      endcase
    end
    // Reference is meaningless across lock loss or a new PID selection
    if (!locked || (pid_sel != pid_sel_q)) begin
      ref_valid_nxt = 1'b0;
      dup_nxt       = 1'b0;
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves one count
  always_comb begin
    cnt_nxt = err_count;
    if (reset_counter) begin
      cnt_nxt = err_c ? ERR_CNT_W'(1) : '0;
    end else if (err_c && (err_count != '1)) begin
      cnt_nxt = ERR_CNT_W'(err_count + ERR_CNT_W'(1));
    end
  end

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Scoreboard bench for ts_cc_monitor: packet-level reference model, random traffic.
module tb_ts_cc_monitor;
  import ts_pkg::*;

  localparam int unsigned LOCK_N = 3;
  localparam int unsigned LOSS_N = 3;
  localparam logic [19:0] IDLE_T = 20'd400;

  typedef struct packed {
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] pid_sel;
  logic        reset_counter;
  logic        signal_present;
  logic [7:0]  err_count;
  logic        cc_err;
  logic        pkt_strobe;

  ts_cc_monitor_if bus ();

  ts_cc_monitor #(
    .LOCK_CNT    (LOCK_N),
    .LOSS_CNT    (LOSS_N),
    .IDLE_TIMEOUT(IDLE_T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ts_bus        (bus),
    .pid_sel       (pid_sel),
    .reset_counter (reset_counter),
    .signal_present(signal_present),
    .err_count     (err_count),
    .cc_err        (cc_err),
    .pkt_strobe    (pkt_strobe)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t e_pop;
  logic exp_sp     = 1'b0;
  logic sp_chk_en  = 1'b0;

  // Reference model state (packet level)
  logic m_locked = 1'b0;
  int   m_run    = 0;
  int   m_miss   = 0;
  logic [3:0] m_ref = '0;
  logic m_refv   = 1'b0;
  logic m_dup    = 1'b0;
  int   m_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expectation on every header strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (sp_chk_en) chk("signal_present", 32'(signal_present), 32'(exp_sp));
      if (pkt_strobe) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: actual=1 required=0 @%0t", $time);
        end else begin
          e_pop = exp_q.pop_front();
          chk("cc_err", 32'(cc_err), 32'(e_pop.err));
          chk("err_count", 32'(err_count), 32'(e_pop.cnt));
        end
      end else begin
        chk("cc_err_no_strobe", 32'(cc_err), 32'(0));
      end
    end
  end

  function automatic void model_unlock();
    m_locked = 1'b0;
    m_run    = 0;
    m_refv   = 1'b0;
    m_dup    = 1'b0;
  endfunction

  // Continuity/TEI rules evaluated on one parsed header
  function automatic logic model_check(input logic tei, input logic [12:0] pid,
                                       input logic [1:0] afc, input logic [3:0] cc);
    logic e;
    if (pid != pid_sel || pid_sel == 13'h1FFF) return 1'b0;
    if (tei) return 1'b1;
    if (afc == 2'b00) return 1'b0;
    if (!m_refv) begin
      m_ref  = cc;
      m_refv = 1'b1;
      m_dup  = 1'b0;
      return 1'b0;
    end
    if (afc[0]) begin
      if (int'(cc) == (int'(m_ref) + 1) % 16) begin
        e = 1'b0; m_dup = 1'b0;
      end else if (cc == m_ref) begin
        e = m_dup; m_dup = 1'b1;
      end else begin
        e = 1'b1; m_dup = 1'b0;
      end
    end else begin
      e = (cc != m_ref);
    end
    m_ref = cc;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.ts_data  = b;
    bus.ts_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.ts_valid = 1'b0;
  endtask

  task automatic gap();
    int g;
    g = (($urandom % 16) == 0) ? int'($urandom_range(1, 3)) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_rst();
    chk("strobe_before_rst", 32'(pkt_strobe), 32'(1));
    rst = 1'b1;
    #1;
    chk("rst_signal_present", 32'(signal_present), 32'(0));
    chk("rst_err_count", 32'(err_count), 32'(0));
    chk("rst_cc_err", 32'(cc_err), 32'(0));
    chk("rst_pkt_strobe", 32'(pkt_strobe), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_unlock();
    m_miss = 0;
    m_cnt  = 0;
    exp_sp = 1'b0;
  endtask

  task automatic send_pkt(input logic sync_ok, input logic tei, input logic [12:0] pid,
                          input logic [1:0] afc, input logic [3:0] cc, input logic rc3,
                          input int rst_at);
    logic parse;
    logic e;
    logic [7:0] b;
    exp_t x;
    send_byte(sync_ok ? TS_SYNC_BYTE : 8'($urandom_range(0, 63)));
    parse = 1'b0;
    if (sync_ok) begin
      if (m_locked) begin
        m_miss = 0; parse = 1'b1;
      end else begin
        m_run++;
        if (m_run >= int'(LOCK_N)) begin
          model_unlock();
          m_locked = 1'b1; m_miss = 0; parse = 1'b1;
        end
      end
    end else if (m_locked) begin
      m_miss++;
      if (m_miss >= int'(LOSS_N)) model_unlock();
    end else begin
      m_run = 0;
    end
    exp_sp = m_locked;
    gap();
    send_byte({tei, 2'b00, pid[12:8]});
    gap();
    send_byte(pid[7:0]);
    gap();
    reset_counter = rc3;
    send_byte({2'b00, afc, cc});
    reset_counter = 1'b0;
    e = parse ? model_check(tei, pid, afc, cc) : 1'b0;
    if (rc3) m_cnt = e ? 1 : 0;
    else if (e && m_cnt < 255) m_cnt++;
    if (parse) begin
      x.err = e;
      x.cnt = 8'(m_cnt);
      exp_q.push_back(x);
    end
    for (int i = 0; i < 184; i++) begin
      if (i == rst_at) do_rst();
      gap();
      b = 8'($urandom);
      if (b == TS_SYNC_BYTE) b = 8'h48;
      send_byte(b);
    end
  endtask

  task automatic go_idle(input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == int'(IDLE_T) + 1) begin
        model_unlock();
        exp_sp = 1'b0;
      end
    end
  endtask

  task automatic set_pid_sel(input logic [12:0] p);
    if (p != pid_sel) begin
      m_refv = 1'b0;
      m_dup  = 1'b0;
    end
    pid_sel = p;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  cc;
    logic [1:0]  afc;
    logic [12:0] pid;
    int          r;
    rst          = 1'b1;
    bus.ts_data  = 8'h00;
    bus.ts_valid = 1'b0;
    pid_sel      = 13'h100;
    reset_counter = 1'b0;
    #1;
    chk("reset_signal_present", 32'(signal_present), 32'(0));
    chk("reset_err_count", 32'(err_count), 32'(0));
    chk("reset_cc_err", 32'(cc_err), 32'(0));
    chk("reset_pkt_strobe", 32'(pkt_strobe), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sp_chk_en = 1'b1;

    // Lock acquisition
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd0, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd1, 0, -1);
    chk("t1_not_locked_yet", 32'(signal_present), 32'(0));
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd2, 0, -1);
    chk("t1_locked", 32'(signal_present), 32'(1));
    chk("t1_err_count", 32'(err_count), 32'(0));

    // CC gap
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd3, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd4, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd5, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd7, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd8, 0, -1);
    chk("t2_err_count", 32'(err_count), 32'(1));

    // Duplicates and adaptation-only packets
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd9, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd9, 0, -1);
    chk("t3_single_dup", 32'(err_count), 32'(1));
    send_pkt(1, 0, 13'h100, AFC_BOTH, 4'd10, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_BOTH, 4'd10, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_BOTH, 4'd10, 0, -1);
    chk("t3_triple_dup", 32'(err_count), 32'(2));
    send_pkt(1, 0, 13'h100, AFC_ADAPT, 4'd10, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_ADAPT, 4'd11, 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd12, 0, -1);
    chk("t3_err_count", 32'(err_count), 32'(3));

    // Saturation and clear
    for (int i = 0; i < 260; i++) send_pkt(1, 1, 13'h100, AFC_PAYLOAD, 4'(i), 0, -1);
    chk("t4_saturated", 32'(err_count), 32'hFF);
    send_pkt(1, 1, 13'h100, AFC_PAYLOAD, 4'd5, 1, -1);
    chk("t4_clear_with_err", 32'(err_count), 32'(1));
    reset_counter = 1'b1;
    @(posedge clk);
    #1;
    reset_counter = 1'b0;
    m_cnt = 0;
    chk("t4_clear_alone", 32'(err_count), 32'(0));
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd13, 0, -1);

    // Lock loss by missing syncs, then by idle timeout
    send_pkt(0, 0, 13'h100, AFC_PAYLOAD, 4'd14, 0, -1);
    send_pkt(0, 0, 13'h100, AFC_PAYLOAD, 4'd15, 0, -1);
    chk("t5_still_locked", 32'(signal_present), 32'(1));
    send_pkt(0, 0, 13'h100, AFC_PAYLOAD, 4'd0, 0, -1);
    chk("t5_lost_sync", 32'(signal_present), 32'(0));
    for (int i = 1; i <= 3; i++) send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'(i), 0, -1);
    chk("t5_relocked", 32'(signal_present), 32'(1));
    go_idle(int'(IDLE_T) + 5);
    chk("t5_idle_loss", 32'(signal_present), 32'(0));
    for (int i = 4; i <= 6; i++) send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'(i), 0, -1);

    // PID filtering and disabled checking
    for (int i = 0; i < 4; i++) send_pkt(1, 0, 13'h200, AFC_PAYLOAD, 4'($urandom), 0, -1);
    chk("t6_other_pid", 32'(err_count), 32'(0));
    set_pid_sel(13'h1FFF);
    send_pkt(1, 1, 13'h1FFF, AFC_PAYLOAD, 4'd3, 0, -1);
    send_pkt(1, 1, 13'h100, AFC_PAYLOAD, 4'd9, 0, -1);
    send_pkt(1, 0, 13'h1FFF, AFC_PAYLOAD, 4'd0, 0, -1);
    chk("t6_null_sel", 32'(err_count), 32'(0));
    set_pid_sel(13'h100);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      if (($urandom % 15) == 0) set_pid_sel((pid_sel == 13'h100) ? 13'h1FFF : 13'h100);
      pid = (($urandom % 4) == 0) ? 13'h200 : 13'h100;
      afc = (($urandom % 10) == 0) ? AFC_RSVD : ((($urandom % 2) == 0) ? AFC_PAYLOAD : AFC_BOTH);
      r = int'($urandom % 20);
      cc = (r < 12) ? 4'(m_ref + 4'd1) : ((r < 16) ? m_ref : 4'($urandom));
      send_pkt(($urandom % 12) != 0, ($urandom % 10) == 0, pid, afc, cc,
               ($urandom % 20) == 0, -1);
    end
    set_pid_sel(13'h100);

    // Reset mid-packet while a header strobe is high
    for (int i = 0; i < 3; i++) send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'(i), 0, -1);
    send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'd7, 0, 0);
    chk("rst_unlocked", 32'(signal_present), 32'(0));
    for (int i = 0; i < 4; i++) send_pkt(1, 0, 13'h100, AFC_PAYLOAD, 4'(i), 0, -1);
    chk("final_locked", 32'(signal_present), 32'(1));

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
